// File: rtl/fc_credit_gate.sv
// Transmit-side PCIe flow-control gate: keeps limit/consumed registers for the six
// credit fields, loads limits from InitFC/UpdateFC and grants TLPs one cycle after evaluation.
module fc_credit_gate #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fc_upd_valid,
    input  logic              fc_upd_init,
    input  logic [1:0]        fc_upd_type,
    input  logic [HDR_W-1:0]  fc_upd_hdr,
    input  logic [DATA_W-1:0] fc_upd_data,
    input  logic              tlp_req_valid,
    input  logic [1:0]        tlp_req_type,
    input  logic              tlp_req_has_data,
    input  logic [DATA_W-1:0] tlp_req_data_credits,
    output logic              tlp_grant,
    output logic              tlp_blocked,
    output logic              fc_init_done
);

    typedef enum logic [0:0] {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam logic [1:0]        TYPE_RSVD = 2'd3;
    localparam logic [HDR_W-1:0]  HDR_ZERO  = {HDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [HDR_W-1:0]  HDR_ONE   = {{(HDR_W-1){1'b0}}, 1'b1};
    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    // Room left after the request, modulo 2^W; "enough" means room lands in the lower half.
    function automatic logic hdr_fits(input logic [HDR_W-1:0] lim,
                                      input logic [HDR_W-1:0] cons,
                                      input logic [HDR_W-1:0] req);
        logic [HDR_W-1:0] room;
        room = lim - (cons + req);
        return (room <= HDR_HALF);
    endfunction

    function automatic logic data_fits(input logic [DATA_W-1:0] lim,
                                       input logic [DATA_W-1:0] cons,
                                       input logic [DATA_W-1:0] req);
        logic [DATA_W-1:0] room;
        room = lim - (cons + req);
        return (room <= DATA_HALF);
    endfunction

    state_e            state_r;
    logic [HDR_W-1:0]  lim_hdr_r   [0:2];
    logic [DATA_W-1:0] lim_data_r  [0:2];
    logic [HDR_W-1:0]  cons_hdr_r  [0:2];
    logic [DATA_W-1:0] cons_data_r [0:2];
    logic [2:0]        inf_hdr_r;
    logic [2:0]        inf_data_r;
    logic [2:0]        init_rcvd_r;

    logic [1:0]        req_idx_s;
    logic              req_type_ok_s;
    logic [DATA_W-1:0] data_req_s;
    logic              hdr_ok_s;
    logic              data_ok_s;
    logic              eval_s;
    logic              pass_s;

    logic [1:0]        upd_idx_s;
    logic              upd_hit_s;
    logic              init_load_s;
    logic              act_load_s;
    logic [2:0]        init_next_s;

    // Request evaluation against the pre-edge limit/consumed registers.
    always_comb begin
        req_idx_s     = 2'd0;
        req_type_ok_s = 1'b0;
        if (tlp_req_type != TYPE_RSVD) begin
            req_idx_s     = tlp_req_type;
            req_type_ok_s = 1'b1;
        end else begin
            req_idx_s     = 2'd0;
            req_type_ok_s = 1'b0;
        end

        if (tlp_req_has_data) begin
            data_req_s = tlp_req_data_credits;
        end else begin
            data_req_s = DATA_ZERO;
        end

        hdr_ok_s  = inf_hdr_r[req_idx_s]
                  | hdr_fits(lim_hdr_r[req_idx_s], cons_hdr_r[req_idx_s], HDR_ONE);
        data_ok_s = ~tlp_req_has_data
                  | inf_data_r[req_idx_s]
                  | data_fits(lim_data_r[req_idx_s], cons_data_r[req_idx_s], data_req_s);

        eval_s = (state_r == ST_ACTIVE) & tlp_req_valid & ~tlp_grant;
        pass_s = eval_s & req_type_ok_s & hdr_ok_s & data_ok_s;
    end

    // FC DLLP decode: InitFC only counts in INIT (first one per type), UpdateFC only in ACTIVE.
    always_comb begin
        upd_hit_s   = fc_upd_valid & (fc_upd_type != TYPE_RSVD);
        upd_idx_s   = 2'd0;
        init_load_s = 1'b0;
        act_load_s  = 1'b0;
        init_next_s = init_rcvd_r;
        if (upd_hit_s) begin
            upd_idx_s   = fc_upd_type;
            init_load_s = (state_r == ST_INIT) & fc_upd_init & ~init_rcvd_r[fc_upd_type];
            act_load_s  = (state_r == ST_ACTIVE) & ~fc_upd_init;
        end else begin
            upd_idx_s   = 2'd0;
            init_load_s = 1'b0;
            act_load_s  = 1'b0;
        end
        if (init_load_s) begin
            init_next_s = init_rcvd_r | (3'b001 << upd_idx_s);
        end else begin
            init_next_s = init_rcvd_r;
        end
    end

    // Limit, infinite-flag and consumed-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                lim_hdr_r[i]   <= HDR_ZERO;
                lim_data_r[i]  <= DATA_ZERO;
                cons_hdr_r[i]  <= HDR_ZERO;
                cons_data_r[i] <= DATA_ZERO;
            end
            inf_hdr_r   <= 3'b000;
            inf_data_r  <= 3'b000;
            init_rcvd_r <= 3'b000;
        end else begin
            // Consumed counters advance even for infinite fields.
            if (pass_s) begin
                cons_hdr_r[req_idx_s]  <= cons_hdr_r[req_idx_s] + HDR_ONE;
                cons_data_r[req_idx_s] <= cons_data_r[req_idx_s] + data_req_s;
            end
            if (init_load_s) begin
                lim_hdr_r[upd_idx_s]  <= fc_upd_hdr;
                lim_data_r[upd_idx_s] <= fc_upd_data;
                inf_hdr_r[upd_idx_s]  <= (fc_upd_hdr == HDR_ZERO);
                inf_data_r[upd_idx_s] <= (fc_upd_data == DATA_ZERO);
                init_rcvd_r           <= init_next_s;
            end
            if (act_load_s) begin
                if (!inf_hdr_r[upd_idx_s]) begin
                    lim_hdr_r[upd_idx_s] <= fc_upd_hdr;
                end
                if (!inf_data_r[upd_idx_s]) begin
                    lim_data_r[upd_idx_s] <= fc_upd_data;
                end
            end
        end
    end

    // Link-init FSM with registered grant/blocked/init-done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_INIT;
            tlp_grant    <= 1'b0;
            tlp_blocked  <= 1'b0;
            fc_init_done <= 1'b0;
        end else begin
            tlp_grant   <= pass_s;
            tlp_blocked <= eval_s & ~pass_s;
            case (state_r)
                ST_INIT: begin
                    if (&init_next_s) begin
                        state_r      <= ST_ACTIVE;
                        fc_init_done <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    state_r      <= ST_ACTIVE;
                    fc_init_done <= 1'b1;
                end
                default: begin
                    state_r      <= ST_INIT;
                    fc_init_done <= 1'b0;
                end
            endcase
        end
    end

    fc_credit_gate_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .tlp_grant    (tlp_grant),
        .tlp_blocked  (tlp_blocked),
        .fc_init_done (fc_init_done)
    );

endmodule

// Handshake invariants of the gate outputs.
module fc_credit_gate_chk (
    input logic clk,
    input logic rst,
    input logic tlp_grant,
    input logic tlp_blocked,
    input logic fc_init_done
);

    a_grant_xor_blocked: assert property (@(posedge clk) disable iff (rst)
        !(tlp_grant && tlp_blocked));

    a_no_back_to_back: assert property (@(posedge clk) disable iff (rst)
        tlp_grant |=> !tlp_grant);

    a_quiet_until_init: assert property (@(posedge clk) disable iff (rst)
        !fc_init_done |-> (!tlp_grant && !tlp_blocked));

endmodule

// File: tb/tb_fc_credit_gate.sv
// Bench for fc_credit_gate: directed test-plan steps plus a randomized phase, all
// checked against a credit-ledger reference model kept in integer arithmetic.
module tb_fc_credit_gate;

    localparam int HDR_W  = 8;
    localparam int DATA_W = 12;
    localparam int HMOD   = 256;
    localparam int DMOD   = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              fc_upd_valid;
    logic              fc_upd_init;
    logic [1:0]        fc_upd_type;
    logic [HDR_W-1:0]  fc_upd_hdr;
    logic [DATA_W-1:0] fc_upd_data;
    logic              tlp_req_valid;
    logic [1:0]        tlp_req_type;
    logic              tlp_req_has_data;
    logic [DATA_W-1:0] tlp_req_data_credits;
    logic              tlp_grant;
    logic              tlp_blocked;
    logic              fc_init_done;

    always #5 clk = ~clk;

    fc_credit_gate #(.HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fc_upd_valid         (fc_upd_valid),
        .fc_upd_init          (fc_upd_init),
        .fc_upd_type          (fc_upd_type),
        .fc_upd_hdr           (fc_upd_hdr),
        .fc_upd_data          (fc_upd_data),
        .tlp_req_valid        (tlp_req_valid),
        .tlp_req_type         (tlp_req_type),
        .tlp_req_has_data     (tlp_req_has_data),
        .tlp_req_data_credits (tlp_req_data_credits),
        .tlp_grant            (tlp_grant),
        .tlp_blocked          (tlp_blocked),
        .fc_init_done         (fc_init_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference ledger: per credit class, limits, consumed totals and infinite flags.
    bit m_active;
    bit m_init   [3];
    int m_lim_h  [3];
    int m_lim_d  [3];
    int m_con_h  [3];
    int m_con_d  [3];
    bit m_inf_h  [3];
    bit m_inf_d  [3];
    bit m_grant_prev;
    bit exp_grant;
    bit exp_blocked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit fits(input int lim, input int con, input int req, input int modv);
        int room;
        room = ((lim - con - req) % modv + modv) % modv;
        return room <= modv / 2;
    endfunction

    task automatic model_reset();
        m_active     = 1'b0;
        m_grant_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_init[i]  = 1'b0;
            m_lim_h[i] = 0;
            m_lim_d[i] = 0;
            m_con_h[i] = 0;
            m_con_d[i] = 0;
            m_inf_h[i] = 1'b0;
            m_inf_d[i] = 1'b0;
        end
    endtask

    // Predict the coming edge from the driven inputs, clock it, compare all outputs.
    task automatic tick(input string tag);
        bit g;
        bit b;
        int t;
        int dreq;
        g = 1'b0;
        b = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_active && tlp_req_valid && !m_grant_prev) begin
                t    = int'(tlp_req_type);
                dreq = tlp_req_has_data ? int'(tlp_req_data_credits) : 0;
                if (t != 3 && (m_inf_h[t] || fits(m_lim_h[t], m_con_h[t], 1, HMOD))
                           && (!tlp_req_has_data || m_inf_d[t] || fits(m_lim_d[t], m_con_d[t], dreq, DMOD))) begin
                    g          = 1'b1;
                    m_con_h[t] = (m_con_h[t] + 1) % HMOD;
                    m_con_d[t] = (m_con_d[t] + dreq) % DMOD;
                end else begin
                    b = 1'b1;
                end
            end
            if (fc_upd_valid && fc_upd_type != 2'd3) begin
                t = int'(fc_upd_type);
                if (!m_active && fc_upd_init && !m_init[t]) begin
                    m_lim_h[t] = int'(fc_upd_hdr);
                    m_lim_d[t] = int'(fc_upd_data);
                    m_inf_h[t] = (m_lim_h[t] == 0);
                    m_inf_d[t] = (m_lim_d[t] == 0);
                    m_init[t]  = 1'b1;
                end else if (m_active && !fc_upd_init) begin
                    if (!m_inf_h[t]) m_lim_h[t] = int'(fc_upd_hdr);
                    if (!m_inf_d[t]) m_lim_d[t] = int'(fc_upd_data);
                end
            end
            if (!m_active && m_init[0] && m_init[1] && m_init[2]) m_active = 1'b1;
        end
        m_grant_prev = g;
        exp_grant    = g;
        exp_blocked  = b;
        @(posedge clk);
        #1;
        chk({tag, ".grant"}, tlp_grant, g);
        chk({tag, ".blocked"}, tlp_blocked, b);
        chk({tag, ".init_done"}, fc_init_done, m_active);
    endtask

    task automatic fc(input bit init, input int t, input int h, input int d, input string tag);
        fc_upd_valid = 1'b1;
        fc_upd_init  = init;
        fc_upd_type  = t[1:0];
        fc_upd_hdr   = h[HDR_W-1:0];
        fc_upd_data  = d[DATA_W-1:0];
        tick(tag);
        fc_upd_valid = 1'b0;
    endtask

    task automatic req(input int t, input bit hd, input int dc);
        tlp_req_valid        = 1'b1;
        tlp_req_type         = t[1:0];
        tlp_req_has_data     = hd;
        tlp_req_data_credits = dc[DATA_W-1:0];
    endtask

    task automatic clr_req();
        tlp_req_valid = 1'b0;
    endtask

    int wrap_grants;
    int wrap_blocks;
    int hold;
    int rt;
    int ut;
    int uh;
    int ud;

    initial begin
        model_reset();
        rst = 1'b1;
        fc_upd_valid = 1'b0; fc_upd_init = 1'b0; fc_upd_type = 2'd0;
        fc_upd_hdr = '0; fc_upd_data = '0;
        tlp_req_valid = 1'b0; tlp_req_type = 2'd0; tlp_req_has_data = 1'b0;
        tlp_req_data_credits = '0;
        @(negedge clk);

        // Reset state
        tick("reset");
        chk("reset_grant", tlp_grant, 0);
        chk("reset_blocked", tlp_blocked, 0);
        chk("reset_done", fc_init_done, 0);
        rst = 1'b0;

        // Gating in INIT: a held request waits for all three InitFCs
        fc(1'b1, 0, 4, 16, "initP");
        req(0, 1'b1, 2);
        repeat (3) begin
            tick("init_hold");
            chk("init_no_grant", tlp_grant, 0);
            chk("init_not_done", fc_init_done, 0);
        end
        fc(1'b1, 1, 8, 32, "initNP");
        fc(1'b1, 2, 8, 32, "initCpl");
        chk("init_done", fc_init_done, 1);
        chk("init_done_no_grant", tlp_grant, 0);
        tick("init_grant");
        chk("init_held_grant", tlp_grant, 1);
        clr_req();
        tick("idle");

        // Fresh link: P 4/16, NP 2/64, Cpl infinite
        rst = 1'b1; tick("rst2"); rst = 1'b0;
        fc(1'b1, 0, 4, 16, "initP2");
        fc(1'b1, 1, 2, 64, "initNP2");
        fc(1'b1, 2, 0, 0, "initCpl2");
        chk("init2_done", fc_init_done, 1);

        // Basic consumption
        req(0, 1'b1, 8);
        tick("basic8");
        chk("basic_grant8", tlp_grant, 1);
        clr_req(); tick("gap");
        req(0, 1'b1, 9);
        tick("basic9");
        chk("basic_block9", tlp_blocked, 1);
        chk("basic_nogrant9", tlp_grant, 0);
        tick("basic9b");
        chk("basic_block9b", tlp_blocked, 1);
        fc(1'b0, 0, 4, 17, "updP");
        chk("blocked_during_upd", tlp_blocked, 1);
        tick("basic_after_upd");
        chk("basic_grant_after_upd", tlp_grant, 1);
        clr_req(); tick("gap");

        // Header exhaustion on NP
        req(1, 1'b0, 0);
        tick("np1"); chk("np1_grant", tlp_grant, 1);
        tick("np_gap"); chk("np_gap_nogrant", tlp_grant, 0);
        tick("np2"); chk("np2_grant", tlp_grant, 1);
        tick("np_gap2");
        tick("np3"); chk("np3_blocked", tlp_blocked, 1); chk("np3_nogrant", tlp_grant, 0);
        fc(1'b0, 1, 3, 64, "updNP3");
        chk("np3_blocked_same_cycle", tlp_blocked, 1);
        tick("np3_after"); chk("np3_grant", tlp_grant, 1);
        fc(1'b0, 1, 5, 64, "updNP5");

        // Header wrap-around: 300 grants with the limit kept two ahead
        wrap_grants = 0;
        wrap_blocks = 0;
        for (int i = 0; i < 300; i++) begin
            tick("wrap");
            if (tlp_grant === 1'b1) wrap_grants++;
            if (tlp_blocked === 1'b1) wrap_blocks++;
            fc(1'b0, 1, (m_con_h[1] + 2) % HMOD, 64, "wrap_upd");
        end
        chk("wrap_all_granted", wrap_grants, 300);
        chk("wrap_never_blocked", wrap_blocks, 0);
        clr_req(); tick("gap");

        // Infinite Cpl credits, and an UpdateFC that must not change them
        for (int i = 0; i < 10; i++) begin
            req(2, 1'b1, 4095);
            tick("inf"); chk("inf_grant", tlp_grant, 1);
            clr_req(); tick("inf_gap");
        end
        fc(1'b0, 2, 1, 1, "updCpl_ignored");
        for (int i = 0; i < 3; i++) begin
            req(2, 1'b1, 4095);
            tick("inf2"); chk("inf_after_upd_grant", tlp_grant, 1);
            clr_req(); tick("inf2_gap");
        end

        // Reset on the edge that would have carried a grant
        req(2, 1'b1, 100);
        rst = 1'b1;
        tick("rst_mid");
        chk("rst_mid_nogrant", tlp_grant, 0);
        chk("rst_mid_done", fc_init_done, 0);
        rst = 1'b0;
        repeat (2) begin
            tick("rst_mid_init");
            chk("rst_mid_quiet", tlp_grant, 0);
        end
        clr_req();
        fc(1'b1, 0, 1, 1, "reinitP");
        fc(1'b1, 1, 1, 1, "reinitNP");
        fc(1'b1, 2, 1, 1, "reinitCpl");
        req(0, 1'b1, 1);
        tick("post_rst"); chk("post_rst_consumed_zero", tlp_grant, 1);
        clr_req(); tick("gap");
        req(0, 1'b1, 1);
        tick("post_rst2"); chk("post_rst_exhausted", tlp_blocked, 1);
        clr_req(); tick("gap");

        // Randomized traffic with concurrent updates and occasional resets
        rst = 1'b1; tick("rst_rand"); rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            uh = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            ud = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 200));
            fc(1'b1, t, uh, ud, "rand_init");
        end
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!tlp_req_valid && $urandom_range(0, 2) != 0) begin
                rt = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
                req(rt, $urandom_range(0, 1) == 1, int'($urandom_range(0, 40)));
                hold = 0;
            end
            if ($urandom_range(0, 3) == 0) begin
                ut = int'($urandom_range(0, 3));
                if (ut < 3) begin
                    uh = (m_con_h[ut] + int'($urandom_range(0, 5))) % HMOD;
                    ud = (m_con_d[ut] + int'($urandom_range(0, 60))) % DMOD;
                end else begin
                    uh = int'($urandom_range(0, 255));
                    ud = int'($urandom_range(0, 4095));
                end
                if ($urandom_range(0, 9) == 0) uh = int'($urandom_range(0, 255));
                fc_upd_valid = 1'b1;
                fc_upd_init  = ($urandom_range(0, 7) == 0);
                fc_upd_type  = ut[1:0];
                fc_upd_hdr   = uh[HDR_W-1:0];
                fc_upd_data  = ud[DATA_W-1:0];
            end
            rst = ($urandom_range(0, 499) == 0);
            tick("rand");
            fc_upd_valid = 1'b0;
            rst = 1'b0;
            if (exp_grant) begin
                clr_req();
            end else if (tlp_req_valid) begin
                hold++;
                if (hold > 10) clr_req();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
